// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer
// Purpose: Sweeps every input combination into a gate under test. It samples
// the gate output once per vector and compares it with the NAND reference
// (~&vec_out). It counts mismatches, saturating at 255, and reports pass/fail
// when the sweep ends.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - begin a sweep (honoured only in IDLE or DONE)
//   vec_out    - stimulus, bit 0 = input a, bit 1 = input b, ...
//   dut_r      - gate output under test (sampled only in CHECK)
//   busy       - sweep in progress (SETTLE or CHECK)
//   done       - sweep finished
//   pass       - sweep finished with zero mismatches
//   err_count  - mismatch count of the current/last sweep, saturating
//
// Optional feature macro: GATE_SEQ_FIRST_FAIL_EN
//   Adds fail_valid / fail_vec, which capture the vector of the first
//   mismatch in a sweep.
//
// state  | meaning
// IDLE   | waiting for start, outputs at reset values
// SETTLE | holding vec_out for SETTLE_CYCLES+1 cycles
// CHECK  | one-cycle compare of dut_r against ~&vec_out
// DONE   | sweep finished, results held until next start
module gate_vector_sequencer #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_INPUTS-1:0] vec_out,
  input  logic                dut_r,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count
`ifdef GATE_SEQ_FIRST_FAIL_EN
  ,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_vec
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]          SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [N_INPUTS-1:0] VEC_LAST    = {N_INPUTS{1'b1}};

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fvalid_q, fvalid_d;
  logic [N_INPUTS-1:0] fvec_q, fvec_d;
  logic                expected;
  logic                mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    expected = ~&vec_q;
    mismatch = (dut_r != expected);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          vec_d    = '0;
          cnt_d    = SETTLE_LOAD;
          err_d    = 8'd0;
          fvalid_d = 1'b0;
          fvec_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != 8'hff) err_d = err_q + 8'd1;
          // Only the first mismatch of a sweep is captured.
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_d == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      cnt_q    <= 8'd0;
      err_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

`ifdef GATE_SEQ_FIRST_FAIL_EN
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
`else
  // First-fail capture exists only when the feature is enabled.
  logic unused_ffail;
  assign unused_ffail = fvalid_q ^ (^fvec_q);
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Testbench for gate_vector_sequencer.
// Instance A (N_INPUTS=2, SETTLE_CYCLES=1) runs a table of sweeps with
// different gate behaviours. Instance B (N_INPUTS=9, SETTLE_CYCLES=0)
// exercises the saturation of err_count.
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [1:0] vec_a;
  logic       dut_r_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [8:0] vec_b;
  logic       dut_r_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
`ifdef GATE_SEQ_FIRST_FAIL_EN
  logic       fv_a, fv_b;
  logic [1:0] fvec_a;
  logic [8:0] fvec_b;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // 0: correct NAND, 1: tied high, 2: tied low, 3: inverted NAND (AND)
  always_comb begin
    case (mode)
      2'd0:    dut_r_a = ~&vec_a;
      2'd1:    dut_r_a = 1'b1;
      2'd2:    dut_r_a = 1'b0;
      default: dut_r_a = &vec_a;
    endcase
  end
  assign dut_r_b = &vec_b;

  gate_vector_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a),
    .dut_r(dut_r_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_valid(fv_a), .fail_vec(fvec_a)
`endif
  );

  gate_vector_sequencer #(.N_INPUTS(9), .SETTLE_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b),
    .dut_r(dut_r_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b)
`ifdef GATE_SEQ_FIRST_FAIL_EN
    , .fail_valid(fv_b), .fail_vec(fvec_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       mid_start;
    logic [7:0] exp_err;
    logic       exp_pass;
    logic       exp_fv;
    logic [1:0] exp_fvec;
  } vec_t;

  vec_t tbl[4];
  int   n;
  int   k;
  logic step_ok;

  initial begin
    tbl[0] = '{mode: 2'd0, mid_start: 1'b0, exp_err: 8'd0, exp_pass: 1'b1, exp_fv: 1'b0, exp_fvec: 2'd0};
    tbl[1] = '{mode: 2'd1, mid_start: 1'b1, exp_err: 8'd1, exp_pass: 1'b0, exp_fv: 1'b1, exp_fvec: 2'd3};
    tbl[2] = '{mode: 2'd2, mid_start: 1'b0, exp_err: 8'd3, exp_pass: 1'b0, exp_fv: 1'b1, exp_fvec: 2'd0};
    tbl[3] = '{mode: 2'd3, mid_start: 1'b1, exp_err: 8'd4, exp_pass: 1'b0, exp_fv: 1'b1, exp_fvec: 2'd0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_vec", vec_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_pass", pass_a, 0);
    chk("reset_err", err_a, 0);

    // Table of sweeps; each after the first restarts from DONE.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n = 0;
      step_ok = 1'b1;
      chk("start_done_low", done_a, 0);
      chk("start_err_clear", err_a, 0);
      chk("start_busy", busy_a, 1);
      while (!done_a && n < 200) begin
        if (vec_a !== 2'(n / 3) || busy_a !== 1'b1) step_ok = 1'b0;
        start_a = (tbl[i].mid_start && n == 4);
        @(negedge clk);
        n++;
      end
      start_a = 1'b0;
      chk("latency", n, 12);
      chk("vec_step", step_ok, 1);
      chk("err_count", err_a, tbl[i].exp_err);
      chk("pass", pass_a, tbl[i].exp_pass);
      chk("done_busy", busy_a, 0);
      chk("done_vec", vec_a, 3);
`ifdef GATE_SEQ_FIRST_FAIL_EN
      chk("fail_valid", fv_a, tbl[i].exp_fv);
      chk("fail_vec", fvec_a, tbl[i].exp_fvec);
`endif
      repeat (2) @(negedge clk);
      chk("done_hold", done_a, 1);
      chk("err_hold", err_a, tbl[i].exp_err);
    end

    // Reset asserted mid-sweep while vec_out = 2 in SETTLE.
    mode = 2'd0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (vec_a !== 2'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vec2", vec_a, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vec", vec_a, 0);
    chk("async_rst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy_a, done_a}, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("post_rst_latency", n, 12);
    chk("post_rst_err", err_a, 0);
    chk("post_rst_pass", pass_a, 1);

    // Saturation: 512 mismatches on the 9-input instance.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_latency", n, 1024);
    chk("sat_err", err_b, 255);
    chk("sat_pass", pass_b, 0);
    chk("sat_vec", vec_b, 511);
`ifdef GATE_SEQ_FIRST_FAIL_EN
    chk("sat_fail_vec", fvec_b, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Sequential stimulus-and-check stage that wraps the combinational gate labs. It sits upstream of the gate pair, driving all 2^N_INPUTS input combinations. It also sits downstream of the pair, sampling the gate output and comparing it against the NAND reference (~&inputs). It counts mismatches and reports pass/fail, so lab benches need no hand-written assertions.

Parameters:
- N_INPUTS, default 2: number of gate inputs driven; legal range 1..16.
- SETTLE_CYCLES, default 1: extra hold cycles per vector before sampling; legal range 0..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a sweep; sampled only in IDLE or DONE.
- vec_out, output, N_INPUTS: stimulus to the gate inputs; bit 0 = input a, bit 1 = input b, and so on.
- dut_r, input, 1: gate output under test.
- busy, output, 1: high while a sweep is in progress (SETTLE or CHECK).
- done, output, 1: high in DONE.
- pass, output, 1: high in DONE when err_count == 0.
- err_count, output, 8: mismatch count for the current or last sweep; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; vec_out = 0, busy = 0, done = 0, pass = 0, err_count = 0, settle counter = 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: outputs hold their reset values. If start = 1: load vec_out = 0, clear err_count, load the settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - vec_out held; busy = 1.
  - Counter nonzero: decrement it, stay in SETTLE.
  - Counter zero: go to CHECK.
  - Each vector spends SETTLE_CYCLES+1 cycles in SETTLE.
- CHECK (exactly 1 cycle), busy = 1:
  - Expected value = ~&vec_out, evaluated on the registered vec_out.
  - If dut_r != expected: err_count increments, saturating at 255.
  - If vec_out == 2^N_INPUTS-1: go to DONE; vec_out is held.
  - Otherwise: vec_out increments by 1, the counter reloads with SETTLE_CYCLES, and the state returns to SETTLE.
- Timing: each vector occupies SETTLE_CYCLES+2 cycles. done rises exactly 2^N_INPUTS*(SETTLE_CYCLES+2) cycles after the edge that accepted start.
- DONE:
  - done = 1, busy = 0, pass = (err_count == 0).
  - vec_out and err_count hold their values.
  - If start = 1: restart exactly as from IDLE; done and pass drop on the next edge.
- start while busy: ignored; the sweep is not restarted and the counters are unaffected.
- dut_r is sampled only in CHECK; its value in any other state is don't-care.
- vec_out never wraps. The terminal vector ends the sweep; there is no increment past all-ones.
- Reset asserted mid-sweep: the block returns to IDLE immediately and all outputs clear. No partial result is kept.
- err_count arithmetic is 8-bit unsigned with saturation. The compare width is 1 bit.

Optional Feature:
- Macro: GATE_SEQ_FIRST_FAIL_EN.
- Defined: adds two ports.
  - fail_valid, output, 1: set in the CHECK cycle of the first mismatch of a sweep.
  - fail_vec, output, N_INPUTS: captures vec_out at that first mismatch.
  - Both clear to 0 on reset and at sweep start, and hold their values through DONE.
  - Later mismatches do not overwrite them.
- Undefined: neither port exists. All other behaviour is identical.

Test Plan:
- Correct NAND (gate pair), N_INPUTS = 2, SETTLE_CYCLES = 1, pulse start:
  - busy rises next edge.
  - vec_out steps 0, 1, 2, 3, holding each for 3 cycles.
  - done = 1 exactly 12 cycles after start; err_count = 0; pass = 1.
- dut_r tied to 1 (N_INPUTS = 2):
  - Mismatch only at vec_out = 3; err_count = 1, pass = 0.
  - With the macro: fail_valid = 1, fail_vec = 2'b11.
- dut_r tied to 0:
  - err_count = 3, pass = 0.
  - With the macro: fail_vec = 2'b00.
- start pulsed again at the 5th busy cycle:
  - Sweep is unaffected; done still at cycle 12.
  - A start pulse in DONE restarts the sweep; err_count clears, done falls next edge.
- Reset mid-sweep: assert rst_n = 0 while vec_out = 2 during SETTLE.
  - Outputs clear asynchronously (vec_out = 0, busy = 0); state returns to IDLE.
  - A fresh start then completes normally.
- Saturation: N_INPUTS = 9, SETTLE_CYCLES = 0, dut_r = ~expected.
  - 512 mismatches; err_count = 255.
  - done after 1024 cycles; pass = 0.
